// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU/LSU request-response channels and the downstream memory port.
// The arbiter takes the master view; the surrounding core/memory model takes the slave view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_rsp_valid;
    logic [DATA_W-1:0]     ifu_rsp_data;
    logic                  ifu_rsp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wstrb;
    logic                  lsu_rsp_valid;
    logic [DATA_W-1:0]     lsu_rsp_data;
    logic                  lsu_rsp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;
    logic                  mem_rsp_err;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction
// in flight, with a watchdog that turns a hung access into an error response.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);
    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
    typedef enum logic {OwnIfu, OwnLsu} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q, last_d;
    logic [CntW-1:0]     wd_q, wd_d, wd_inc;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [StrbW-1:0]    mem_wstrb_q, mem_wstrb_d;

    logic                grant_ifu, grant_lsu, timeout_hit;
    logic                rsp_fire, rsp_err;
    logic [DATA_W-1:0]   rsp_data;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_d        = wd_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        grant_ifu   = 1'b0;
        grant_lsu   = 1'b0;
        rsp_fire    = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = '0;
        timeout_hit = (TIMEOUT != 0) && (wd_q == WdLast);
        wd_inc      = (wd_q == '1) ? wd_q : wd_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                // Readies are gated by rst_n so nothing handshakes while reset is held.
                if (rst_n) begin
                    grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_q == OwnLsu);
                    grant_lsu = bus.lsu_req_valid && !grant_ifu;
                end
                if (grant_ifu) begin
                    mem_addr_d  = bus.ifu_addr;
                    mem_wen_d   = 1'b0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    owner_d     = OwnIfu;
                    last_d      = OwnIfu;
                    wd_d        = '0;
                    state_d     = StReq;
                end else if (grant_lsu) begin
                    mem_addr_d  = bus.lsu_addr;
                    mem_wen_d   = bus.lsu_wen;
                    mem_wdata_d = bus.lsu_wdata;
                    mem_wstrb_d = bus.lsu_wstrb;
                    owner_d     = OwnLsu;
                    last_d      = OwnLsu;
                    wd_d        = '0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                wd_d = wd_inc;
                if (timeout_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = StIdle;
                end else if (bus.mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                wd_d = wd_inc;
                // A real response on the timeout cycle takes priority over the watchdog.
                if (bus.mem_rsp_valid) begin
                    rsp_fire = 1'b1;
                    rsp_err  = bus.mem_rsp_err;
                    rsp_data = bus.mem_rsp_data;
                    state_d  = StIdle;
                end else if (timeout_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= OwnIfu;
            last_q      <= OwnLsu;
            wd_q        <= '0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign bus.ifu_req_ready = grant_ifu;
    assign bus.lsu_req_ready = grant_lsu;
    assign bus.ifu_rsp_valid = rsp_fire && (owner_q == OwnIfu);
    assign bus.lsu_rsp_valid = rsp_fire && (owner_q == OwnLsu);
    assign bus.ifu_rsp_data  = rsp_data;
    assign bus.lsu_rsp_data  = rsp_data;
    assign bus.ifu_rsp_err   = rsp_err;
    assign bus.lsu_rsp_err   = rsp_err;
    assign bus.mem_req_valid = (state_q == StReq);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8): single read, round-robin contention,
// held write, watchdog in WAIT and REQ, response-on-timeout-cycle, reset mid-transaction.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    bit   exp_ifu;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h1234_5678;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = '0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = '0;
        bus.lsu_wstrb     = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_err   = 1'b0;

        // Reset state: requests pending but nothing may be granted.
        tick();
        settle();
        chk("rst_ifu_ready", bus.ifu_req_ready, 0);
        chk("rst_lsu_ready", bus.lsu_req_ready, 0);
        chk("rst_mem_valid", bus.mem_req_valid, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wen", bus.mem_wen, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_wstrb", bus.mem_wstrb, 0);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // IFU-only read, response one cycle after accept.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        settle();
        chk("t1_ifu_ready_c0", bus.ifu_req_ready, 1);
        chk("t1_lsu_ready_c0", bus.lsu_req_ready, 0);
        tick();
        bus.ifu_req_valid = 1'b0;
        settle();
        chk("t1_mem_valid_c1", bus.mem_req_valid, 1);
        chk("t1_mem_addr_c1", bus.mem_addr, 32'h8000_0000);
        chk("t1_mem_wen_c1", bus.mem_wen, 0);
        chk("t1_ifu_rsp_c1", bus.ifu_rsp_valid, 0);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0413;
        settle();
        chk("t1_ifu_rsp_c2", bus.ifu_rsp_valid, 1);
        chk("t1_ifu_data_c2", bus.ifu_rsp_data, 32'h0000_0413);
        chk("t1_ifu_err_c2", bus.ifu_rsp_err, 0);
        chk("t1_lsu_rsp_c2", bus.lsu_rsp_valid, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("t1_mem_valid_c3", bus.mem_req_valid, 0);

        // Contention from reset: IFU, LSU, IFU, LSU.
        do_reset();
        bus.ifu_addr      = 32'h0000_1000;
        bus.lsu_addr      = 32'h0000_2000;
        bus.lsu_wen       = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_ifu = (t % 2 == 0);
            settle();
            chk("rr_ifu_ready", bus.ifu_req_ready, exp_ifu);
            chk("rr_lsu_ready", bus.lsu_req_ready, !exp_ifu);
            tick();
            settle();
            chk("rr_mem_addr", bus.mem_addr, exp_ifu ? 32'h0000_1000 : 32'h0000_2000);
            chk("rr_busy_ready", bus.ifu_req_ready | bus.lsu_req_ready, 0);
            tick();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'h100 + t;
            settle();
            chk("rr_ifu_rsp", bus.ifu_rsp_valid, exp_ifu);
            chk("rr_lsu_rsp", bus.lsu_rsp_valid, !exp_ifu);
            chk("rr_rsp_data", exp_ifu ? bus.ifu_rsp_data : bus.lsu_rsp_data, 32'h100 + t);
            tick();
            bus.mem_rsp_valid = 1'b0;
        end
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        tick();

        // LSU write with mem_req_ready low for 3 cycles; upstream fields change after handshake.
        bus.mem_req_ready = 1'b0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_0100;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 32'hDEAD_BEEF;
        bus.lsu_wstrb     = 4'b0011;
        settle();
        chk("wr_lsu_ready", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = 32'h0BAD_0BAD;
        bus.lsu_wdata     = 32'h0;
        bus.lsu_wstrb     = 4'b1111;
        bus.lsu_wen       = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.mem_req_ready = 1'b1;
            settle();
            chk("wr_mem_valid", bus.mem_req_valid, 1);
            chk("wr_mem_addr", bus.mem_addr, 32'h8000_0100);
            chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("wr_mem_wstrb", bus.mem_wstrb, 4'b0011);
            chk("wr_mem_wen", bus.mem_wen, 1);
            tick();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0;
        settle();
        chk("wr_mem_valid_wait", bus.mem_req_valid, 0);
        chk("wr_lsu_rsp", bus.lsu_rsp_valid, 1);
        chk("wr_ifu_rsp", bus.ifu_rsp_valid, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;

        // Watchdog in WAIT: accepted IFU read never answered; error on cycle 8.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h0000_4000;
        settle();
        chk("wd_ifu_ready", bus.ifu_req_ready, 1);
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_rsp_data  = 32'hFFFF_FFFF;
        for (int c = 1; c < 8; c++) begin
            settle();
            chk("wd_no_rsp_early", bus.ifu_rsp_valid, 0);
            tick();
        end
        settle();
        chk("wd_ifu_rsp", bus.ifu_rsp_valid, 1);
        chk("wd_ifu_err", bus.ifu_rsp_err, 1);
        chk("wd_ifu_data", bus.ifu_rsp_data, 0);
        chk("wd_lsu_rsp", bus.lsu_rsp_valid, 0);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h55;
        settle();
        chk("wd_late_ifu", bus.ifu_rsp_valid, 0);
        chk("wd_late_lsu", bus.lsu_rsp_valid, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;

        // Watchdog in REQ: never accepted; request abandoned after the error.
        bus.mem_req_ready = 1'b0;
        bus.ifu_req_valid = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        settle();
        chk("wdreq_mem_valid", bus.mem_req_valid, 1);
        chk("wdreq_ifu_rsp", bus.ifu_rsp_valid, 1);
        chk("wdreq_ifu_err", bus.ifu_rsp_err, 1);
        tick();
        settle();
        chk("wdreq_mem_drop", bus.mem_req_valid, 0);
        bus.mem_req_ready = 1'b1;
        tick();

        // Response arrives exactly on the timeout cycle: real data wins.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b0;
        bus.lsu_addr      = 32'h0000_3000;
        tick();
        bus.lsu_req_valid = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_err   = 1'b0;
        bus.mem_rsp_data  = 32'h0000_CAFE;
        settle();
        chk("race_lsu_rsp", bus.lsu_rsp_valid, 1);
        chk("race_lsu_err", bus.lsu_rsp_err, 0);
        chk("race_lsu_data", bus.lsu_rsp_data, 32'h0000_CAFE);
        tick();
        bus.mem_rsp_valid = 1'b0;

        // Reset in WAIT during an LSU read.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h0000_3004;
        tick();
        tick();
        rst_n             = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        settle();
        chk("mrst_mem_valid", bus.mem_req_valid, 0);
        chk("mrst_ifu_ready", bus.ifu_req_ready, 0);
        chk("mrst_lsu_ready", bus.lsu_req_ready, 0);
        chk("mrst_lsu_rsp", bus.lsu_rsp_valid, 0);
        chk("mrst_mem_addr", bus.mem_addr, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        settle();
        chk("mrst_first_ifu", bus.ifu_req_ready, 1);
        chk("mrst_first_lsu", bus.lsu_req_ready, 0);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
